// File: rtl/min_reader.sv
// Minutes read sequencer for the RTC bus.
// Runs one address phase followed by one read data phase. It then samples the returned
// byte and publishes it on minutos only if it is valid minutes BCD (00..59).
module min_reader #(
  parameter logic [7:0]  REG_ADDR    = 8'h22,
  parameter int unsigned ADDR_CYCLES = 2,
  parameter int unsigned READ_WAIT   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       start,
  input  logic [7:0] bus_data_in,
  output logic       cs,
  output logic       a_d,
  output logic       w_r,
  output logic [7:0] direccion,
  output logic       busy,
  output logic       done,
  output logic       bcd_error,
  output logic [7:0] minutos
);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_e;

  localparam logic [3:0] AddrLast = 4'(ADDR_CYCLES - 1);
  localparam logic [3:0] DataLast = 4'(READ_WAIT - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic       cs_q, cs_d;
  logic       a_d_q, a_d_d;
  logic [7:0] dir_q, dir_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [7:0] min_q, min_d;

  logic bcd_valid;
  assign bcd_valid = (bus_data_in[7:4] <= 4'd5) && (bus_data_in[3:0] <= 4'd9);

  // Next-state, phase counter and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    min_d   = min_q;
    err_d   = 1'b0;
    if (!enable) begin
      // Abort: back to idle, minutos is kept.
      state_d = StIdle;
      cnt_d   = 4'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StAddr;
            cnt_d   = 4'd0;
          end
        end
        StAddr: begin
          if (cnt_q == AddrLast) begin
            state_d = StData;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        StData: begin
          if (cnt_q == DataLast) begin
            // Sampling edge: the only edge at which bus_data_in is used.
            state_d = StDone;
            cnt_d   = 4'd0;
            if (bcd_valid) min_d = bus_data_in;
            else           err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        StDone: begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end
        default: begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end
      endcase
    end

    cs_d   = (state_d == StAddr) || (state_d == StData);
    a_d_d  = (state_d == StData);
    dir_d  = (state_d == StAddr) ? REG_ADDR : 8'h00;
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  // State, counter and output registers; outputs are derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      cs_q    <= 1'b0;
      a_d_q   <= 1'b0;
      dir_q   <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      min_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      a_d_q   <= a_d_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      min_q   <= min_d;
    end
  end

  assign cs        = cs_q;
  assign a_d       = a_d_q;
  assign w_r       = 1'b0;  // This block only ever reads.
  assign direccion = dir_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign bcd_error = err_q;
  assign minutos   = min_q;

endmodule

// File: tb/tb_min_reader.sv
// Directed bench for min_reader. Expected results come from a scoreboard queue.
module tb_min_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       start;
  logic [7:0] bus_data_in;
  logic       cs;
  logic       a_d;
  logic       w_r;
  logic [7:0] direccion;
  logic       busy;
  logic       done;
  logic       bcd_error;
  logic [7:0] minutos;

  typedef struct {
    logic [7:0] min;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model_min;
  int         n_tests = 0;
  int         n_fail  = 0;

  min_reader #(
    .REG_ADDR    (8'h22),
    .ADDR_CYCLES (2),
    .READ_WAIT   (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .start       (start),
    .bus_data_in (bus_data_in),
    .cs          (cs),
    .a_d         (a_d),
    .w_r         (w_r),
    .direccion   (direccion),
    .busy        (busy),
    .done        (done),
    .bcd_error   (bcd_error),
    .minutos     (minutos)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard push: reference model of the BCD check and minutos register.
  task automatic push_exp(input logic [7:0] data);
    exp_t e;
    logic valid;
    valid = (data[7:4] <= 4'd5) && (data[3:0] <= 4'd9);
    if (valid) model_min = data;
    e.min = model_min;
    e.err = !valid;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, sb.size() > 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_minutos"}, minutos, e.min);
      check({tag, "_bcd_error"}, bcd_error, e.err);
    end
  endtask

  task automatic check_idle(input string tag);
    check(tag, {cs, a_d, w_r, direccion, busy, done, bcd_error}, 0);
  endtask

  // One full read with phase-by-phase bus checks; k counts edges after the start edge.
  task automatic run_read(input logic [7:0] data, input string tag);
    int k;
    bit seen;
    @(negedge clk);
    start = 1'b1;
    bus_data_in = data;
    push_exp(data);
    @(negedge clk);
    start = 1'b0;
    k = 0;
    seen = 0;
    while (!seen && k < 20) begin
      if (done) begin
        seen = 1;
      end else begin
        check($sformatf("%s_cs_k%0d", tag, k), cs, 1);
        check($sformatf("%s_busy_k%0d", tag, k), busy, 1);
        check($sformatf("%s_wr_k%0d", tag, k), w_r, 0);
        check($sformatf("%s_ad_k%0d", tag, k), a_d, (k >= 2));
        check($sformatf("%s_dir_k%0d", tag, k), direccion, (k < 2) ? 8'h22 : 8'h00);
        @(negedge clk);
        k++;
      end
    end
    check({tag, "_done_seen"}, seen, 1);
    if (seen) begin
      check({tag, "_done_edge"}, k, 6);
      check({tag, "_cs_at_done"}, cs, 0);
      check({tag, "_ad_at_done"}, a_d, 0);
      check({tag, "_busy_at_done"}, busy, 1);
      pop_check(tag);
    end
    @(negedge clk);
    check({tag, "_idle_after"}, {busy, done, bcd_error, cs}, 0);
  endtask

  initial begin
    int cnt;
    int t;
    int done_t[$];
    reset = 1'b1;
    enable = 1'b1;
    start = 1'b0;
    bus_data_in = 8'h00;
    model_min = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state and idle hold.
    check_idle("reset_outputs");
    check("reset_minutos", minutos, 8'h00);
    for (int i = 0; i < 20; i++) begin
      bus_data_in = 8'(i * 13);
      @(negedge clk);
      check($sformatf("idle_hold_%0d", i), {cs, a_d, w_r, direccion, busy, done, bcd_error, minutos}, 0);
    end

    // Nominal read, invalid data and boundaries.
    run_read(8'h37, "nominal");
    run_read(8'h5A, "bad_5a");
    run_read(8'h60, "bad_60");
    run_read(8'h00, "bound_00");
    run_read(8'h59, "bound_59");
    run_read(8'h9F, "bad_9f");

    // Abort in the second DATA cycle.
    @(negedge clk);
    start = 1'b1;
    bus_data_in = 8'h45;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_in_data", a_d, 1);
    enable = 1'b0;
    @(negedge clk);
    check_idle("abort_next");
    check("abort_minutos", minutos, model_min);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("abort_no_done", cnt, 0);
    enable = 1'b1;
    run_read(8'h21, "after_abort");

    // start held high for three transactions.
    @(negedge clk);
    start = 1'b1;
    bus_data_in = 8'h12;
    for (int i = 0; i < 3; i++) push_exp(8'h12);
    t = 0;
    while (done_t.size() < 3 && t < 40) begin
      @(negedge clk);
      t++;
      if (done) begin
        done_t.push_back(t);
        pop_check("b2b");
        if (done_t.size() == 3) start = 1'b0;
      end
    end
    check("b2b_count", done_t.size(), 3);
    if (done_t.size() == 3) begin
      check("b2b_gap1", done_t[1] - done_t[0], 8);
      check("b2b_gap2", done_t[2] - done_t[1], 8);
    end
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("b2b_no_extra", cnt, 0);

    // Extra start during ADDR is ignored.
    @(negedge clk);
    start = 1'b1;
    bus_data_in = 8'h08;
    push_exp(8'h08);
    @(negedge clk);
    start = 1'b0;
    check("addr_start_in_addr", {cs, a_d}, 2'b10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        cnt++;
        pop_check("addr_start");
      end
    end
    check("addr_start_one_done", cnt, 1);

    // Reset mid-ADDR; start held too, reset must win.
    @(negedge clk);
    start = 1'b1;
    bus_data_in = 8'h44;
    @(negedge clk);
    check("rst_mid_in_addr", {cs, a_d}, 2'b10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    model_min = 8'h00;
    check_idle("rst_mid_outputs");
    check("rst_mid_minutos", minutos, 8'h00);
    run_read(8'h33, "after_reset");

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/min_reader.md
# min_reader

Read-side counterpart of the minutes-setting write sequencer in the RTC control path. On a start pulse it runs one register read on the RTC address/data bus: an address phase presenting the minutes register address, then a read data phase. It samples the returned byte and checks that it is valid BCD. A good value is published on `minutos` for the VGA/display logic and the general control FSM. It drives the same `a_d` / `w_r` / `direccion` signalling that the RTC bus controller already accepts from the write sequencers.

## Interface
- `REG_ADDR`, 8'h22, RTC register address of minutes.
- `ADDR_CYCLES`, 2, address-phase length in clocks; legal 1..15.
- `READ_WAIT`, 4, data-phase length in clocks before sampling; legal 1..15.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high; one clock, sampled on the `clk` rising edge.
- `enable`  in  1  block enable; low = synchronous abort and hold idle.
- `start`  in  1  request a read; sampled only in IDLE.
- `bus_data_in`  in  8  data returned by RTC bus controller during the data phase.
- `cs`  out  1  high while a bus transaction (address or data phase) is in progress.
- `a_d`  out  1  0 = address phase, 1 = data phase.
- `w_r`  out  1  1 = write, 0 = read; always 0 from this block.
- `direccion`  out  8  `REG_ADDR` in address phase, 8'h00 otherwise.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at transaction end.
- `bcd_error`  out  1  one-cycle pulse, coincident with `done`, when the sampled byte is not valid minutes BCD.
- `minutos`  out  8  last valid minutes value (BCD 00..59).

## Operation
- All outputs are registered. Reset values: `cs`=0, `a_d`=0, `w_r`=0, `direccion`=8'h00, `busy`=0, `done`=0, `bcd_error`=0, `minutos`=8'h00. The FSM resets to IDLE and the phase counter (4 bits) to 0.
- FSM states:
  - IDLE: bus outputs at reset values. `start`=1 and `enable`=1 → ADDR, counter cleared.
  - ADDR: `cs`=1, `a_d`=0, `w_r`=0, `direccion`=`REG_ADDR`. Counter increments each clock. After `ADDR_CYCLES` clocks → DATA, counter cleared.
  - DATA: `cs`=1, `a_d`=1, `w_r`=0, `direccion`=8'h00. On the clock edge ending the `READ_WAIT`-th cycle, `bus_data_in` is captured and checked. State → DONE.
  - DONE: `cs`=0, `a_d`=0, `done`=1 for exactly this cycle. Next state is IDLE.
- BCD check: the byte is valid iff the upper nibble ≤ 5 and the lower nibble ≤ 9, i.e. a value in 00..59 BCD.
  - Valid: `minutos` takes the captured byte in the DONE cycle.
  - Invalid: `minutos` holds its previous value and `bcd_error`=1 in the DONE cycle.
- `start` in any state other than IDLE is ignored and not queued. `start` while `enable`=0 is ignored.
- `enable`=0 in any state gives a synchronous abort. Next cycle: state IDLE, `cs`/`a_d`/`w_r`/`direccion`/`busy`/`done`/`bcd_error` at reset values, counter 0. `minutos` is retained; only `reset` clears it.
- `reset` overrides `enable` and `start` when asserted in the same cycle.
- `bus_data_in` is ignored outside the sampling edge.

## Timing
- Edge 0 samples `start`=1 in IDLE. `cs` and `busy` rise after edge 0.
- `a_d` rises after edge `ADDR_CYCLES`.
- Capture happens at edge `ADDR_CYCLES+READ_WAIT`. `done` and the `minutos` update are visible after that same edge; defaults give edge 6.
- `cs` falls together with the `done` rise.
- `busy` falls one cycle after `done` (IDLE).
- With `start` held high, the transaction period is `ADDR_CYCLES+READ_WAIT+2` clocks (8 with defaults).
- No combinational path from any input to any output.

## Test plan
- Reset then idle: after `reset`, all outputs 0 and `minutos`=8'h00. Held `start`=0 → no change for 20 cycles.
- Nominal read, `bus_data_in`=8'h37, one `start` pulse:
  - `cs`=1, `a_d`=0, `direccion`=8'h22 for 2 cycles.
  - `a_d`=1, `direccion`=8'h00 for 4 cycles.
  - `done`=1 and `minutos`=8'h37 six edges after start; `bcd_error`=0.
- Invalid data:
  - Prior `minutos`=8'h37, read returns 8'h5A → `done`=1, `bcd_error`=1, `minutos` stays 8'h37.
  - Repeat with 8'h60 → same result.
- Boundaries: reads of 8'h00 and 8'h59 are accepted with `bcd_error`=0.
- Abort: drop `enable` in the second DATA cycle → next cycle all bus outputs and `busy` are 0, no `done`, `minutos` unchanged. Raising `enable` with `start` → a fresh full transaction.
- Back-to-back:
  - `start` held high for 3 transactions → `done` pulses exactly 8 cycles apart.
  - A `start` pulse during ADDR is ignored → one `done` only.
  - `reset` asserted mid-ADDR → all outputs 0 next cycle, `minutos`=8'h00.
